// File: rtl/rs_multi_wakeup_pkg.sv
// Shared defaults and ALU op encodings for the multi-wakeup reservation station.
package rs_multi_wakeup_pkg;

  localparam int RS_SIZE_BIT_DEF   = 3;
  localparam int ROB_WIDTH_BIT_DEF = 4;
  localparam int RS_TYPE_BIT_DEF   = 4;
  localparam int CDB_NUM_DEF       = 2;
  localparam int XLEN_DEF          = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

endpackage

// File: rtl/rs_age_select.sv
// Oldest-ready picker: grants the executable entry that no other executable entry is older than.
module rs_age_select
  import rs_multi_wakeup_pkg::*;
#(
  parameter int N_BIT = RS_SIZE_BIT_DEF,
  localparam int N    = 1 << N_BIT
) (
  input  logic [N-1:0]         exec,
  input  logic [N-1:0][N-1:0]  older,
  output logic [N-1:0]         grant,
  output logic [N_BIT-1:0]     grant_idx,
  output logic                 any_valid
);

  always_comb begin
    grant = '0;
    for (int i = 0; i < N; i++) begin
      grant[i] = exec[i];
      for (int j = 0; j < N; j++)
        if (exec[j] && older[j][i]) grant[i] = 1'b0;
    end
  end

  always_comb begin
    grant_idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (grant[i]) grant_idx = N_BIT'(i);
  end

  assign any_valid = |grant;

endmodule

// File: rtl/rs_multi_wakeup.sv
// ALU reservation station: multi-port CDB wakeup with bypass, age-ordered issue, whole-station flush.
module rs_multi_wakeup
  import rs_multi_wakeup_pkg::*;
#(
  parameter int RS_SIZE_BIT   = RS_SIZE_BIT_DEF,
  parameter int ROB_WIDTH_BIT = ROB_WIDTH_BIT_DEF,
  parameter int RS_TYPE_BIT   = RS_TYPE_BIT_DEF,
  parameter int CDB_NUM       = CDB_NUM_DEF,
  parameter int XLEN          = XLEN_DEF
) (
  input  logic                             clk_in,
  input  logic                             rst_n_in,
  input  logic                             rdy_in,
  input  logic                             flush_in,
  input  logic                             inst_valid,
  input  logic [RS_TYPE_BIT-1:0]           inst_type,
  input  logic [ROB_WIDTH_BIT-1:0]         inst_rob_id,
  input  logic [XLEN-1:0]                  inst_r1,
  input  logic [XLEN-1:0]                  inst_r2,
  input  logic                             inst_has_dep1,
  input  logic                             inst_has_dep2,
  input  logic [ROB_WIDTH_BIT-1:0]         inst_dep1,
  input  logic [ROB_WIDTH_BIT-1:0]         inst_dep2,
  output logic                             full,
  output logic [RS_SIZE_BIT:0]             count,
  input  logic [CDB_NUM-1:0]               cdb_valid,
  input  logic [CDB_NUM*ROB_WIDTH_BIT-1:0] cdb_rob_id,
  input  logic [CDB_NUM*XLEN-1:0]          cdb_value,
  output logic                             issue_valid,
  input  logic                             issue_ready,
  output logic [RS_TYPE_BIT-1:0]           issue_type,
  output logic [ROB_WIDTH_BIT-1:0]         issue_rob_id,
  output logic [XLEN-1:0]                  issue_r1,
  output logic [XLEN-1:0]                  issue_r2
);

  localparam int N  = 1 << RS_SIZE_BIT;
  localparam int CW = RS_SIZE_BIT + 1;

  logic [N-1:0]             busy_q, has_dep1_q, has_dep2_q;
  logic [RS_TYPE_BIT-1:0]   type_q [N];
  logic [ROB_WIDTH_BIT-1:0] rob_q  [N];
  logic [ROB_WIDTH_BIT-1:0] dep1_q [N];
  logic [ROB_WIDTH_BIT-1:0] dep2_q [N];
  logic [XLEN-1:0]          r1_q   [N];
  logic [XLEN-1:0]          r2_q   [N];
  logic [N-1:0][N-1:0]      older_q;

  logic [N-1:0]             free1, free2, exec, grant;
  logic [XLEN-1:0]          val1 [N];
  logic [XLEN-1:0]          val2 [N];
  logic [XLEN-1:0]          ins_val1, ins_val2;
  logic                     ins_free1, ins_free2;
  logic [RS_SIZE_BIT-1:0]   sel_idx, ins_idx;
  logic                     any_exec, do_ins, do_pop;
  logic [CW-1:0]            busy_cnt;

  // Returns {free, value}; scanning high-to-low lets the lowest matching port win.
  function automatic logic [XLEN:0] resolve(input logic                     has_dep,
                                            input logic [ROB_WIDTH_BIT-1:0] dep,
                                            input logic [XLEN-1:0]          val);
    logic [XLEN:0] r;
    r = {!has_dep, val};
    if (has_dep)
      for (int p = CDB_NUM - 1; p >= 0; p--)
        if (cdb_valid[p] && cdb_rob_id[p*ROB_WIDTH_BIT +: ROB_WIDTH_BIT] == dep)
          r = {1'b1, cdb_value[p*XLEN +: XLEN]};
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < N; i++) begin
      {free1[i], val1[i]} = resolve(has_dep1_q[i], dep1_q[i], r1_q[i]);
      {free2[i], val2[i]} = resolve(has_dep2_q[i], dep2_q[i], r2_q[i]);
      exec[i] = busy_q[i] && free1[i] && free2[i];
    end
    {ins_free1, ins_val1} = resolve(inst_has_dep1, inst_dep1, inst_r1);
    {ins_free2, ins_val2} = resolve(inst_has_dep2, inst_dep2, inst_r2);
  end

  always_comb begin
    ins_idx  = '0;
    busy_cnt = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!busy_q[i]) ins_idx = RS_SIZE_BIT'(i);
      busy_cnt = busy_cnt + CW'(busy_q[i]);
    end
  end

  rs_age_select #(.N_BIT(RS_SIZE_BIT)) u_age_select (
    .exec      (exec),
    .older     (older_q),
    .grant     (grant),
    .grant_idx (sel_idx),
    .any_valid (any_exec)
  );

  assign full        = &busy_q;
  assign count       = busy_cnt;
  assign issue_valid = any_exec && rdy_in && !flush_in;
  assign do_pop      = issue_valid && issue_ready;
  assign do_ins      = inst_valid && !full && rdy_in && !flush_in;

  always_comb begin
    issue_type   = '0;
    issue_rob_id = '0;
    issue_r1     = '0;
    issue_r2     = '0;
    if (any_exec) begin
      issue_type   = type_q[sel_idx];
      issue_rob_id = rob_q[sel_idx];
      issue_r1     = val1[sel_idx];
      issue_r2     = val2[sel_idx];
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy_q     <= '0;
      has_dep1_q <= '0;
      has_dep2_q <= '0;
      older_q    <= '0;
      for (int i = 0; i < N; i++) begin
        type_q[i] <= '0;
        rob_q[i]  <= '0;
        dep1_q[i] <= '0;
        dep2_q[i] <= '0;
        r1_q[i]   <= '0;
        r2_q[i]   <= '0;
      end
    end else if (rdy_in) begin
      if (flush_in) begin
        busy_q  <= '0;
        older_q <= '0;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (busy_q[i] && has_dep1_q[i] && free1[i]) begin
            r1_q[i]       <= val1[i];
            has_dep1_q[i] <= 1'b0;
          end
          if (busy_q[i] && has_dep2_q[i] && free2[i]) begin
            r2_q[i]       <= val2[i];
            has_dep2_q[i] <= 1'b0;
          end
        end
        if (do_pop) busy_q[sel_idx] <= 1'b0;
        if (do_ins) begin
          busy_q[ins_idx]     <= 1'b1;
          type_q[ins_idx]     <= inst_type;
          rob_q[ins_idx]      <= inst_rob_id;
          r1_q[ins_idx]       <= ins_val1;
          r2_q[ins_idx]       <= ins_val2;
          has_dep1_q[ins_idx] <= !ins_free1;
          has_dep2_q[ins_idx] <= !ins_free2;
          dep1_q[ins_idx]     <= inst_dep1;
          dep2_q[ins_idx]     <= inst_dep2;
          // New entry is younger than every survivor; its stale row is wiped.
          for (int j = 0; j < N; j++) begin
            older_q[j][ins_idx] <= busy_q[j] && !(do_pop && grant[j]);
            older_q[ins_idx][j] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_multi_wakeup.sv
// Directed bench for rs_multi_wakeup: ordering, wakeup/bypass, full, flush, async reset, stall.
module tb_rs_multi_wakeup;
  import rs_multi_wakeup_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_n_in, rdy_in, flush_in, inst_valid;
  logic [3:0]  inst_type, inst_rob_id, inst_dep1, inst_dep2;
  logic [31:0] inst_r1, inst_r2;
  logic        inst_has_dep1, inst_has_dep2;
  logic        full;
  logic [3:0]  count;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_rob_id;
  logic [63:0] cdb_value;
  logic        issue_valid, issue_ready;
  logic [3:0]  issue_type, issue_rob_id;
  logic [31:0] issue_r1, issue_r2;

  int checks = 0;
  int errors = 0;

  logic [3:0]  exp_tag [7] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9};
  logic [31:0] exp_r1  [7] = '{32'h12, 32'h13, 32'h14, 32'h15, 32'h16, 32'h17, 32'h99};

  rs_multi_wakeup dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .inst_valid(inst_valid), .inst_type(inst_type), .inst_rob_id(inst_rob_id),
    .inst_r1(inst_r1), .inst_r2(inst_r2),
    .inst_has_dep1(inst_has_dep1), .inst_has_dep2(inst_has_dep2),
    .inst_dep1(inst_dep1), .inst_dep2(inst_dep2),
    .full(full), .count(count),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_type(issue_type),
    .issue_rob_id(issue_rob_id), .issue_r1(issue_r1), .issue_r2(issue_r2)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    inst_valid = 1'b0; inst_type = '0; inst_rob_id = '0;
    inst_r1 = '0; inst_r2 = '0;
    inst_has_dep1 = 1'b0; inst_has_dep2 = 1'b0; inst_dep1 = '0; inst_dep2 = '0;
    cdb_valid = '0; cdb_rob_id = '0; cdb_value = '0; flush_in = 1'b0;
  endtask

  task automatic disp(input logic [3:0] tag, input logic [31:0] a, input logic [31:0] b);
    inst_valid = 1'b1; inst_type = ALU_ADD; inst_rob_id = tag;
    inst_r1 = a; inst_r2 = b;
    inst_has_dep1 = 1'b0; inst_has_dep2 = 1'b0; inst_dep1 = '0; inst_dep2 = '0;
  endtask

  task automatic set_cdb(input int p, input logic [3:0] tag, input logic [31:0] val);
    cdb_valid[p] = 1'b1;
    cdb_rob_id[p*4 +: 4] = tag;
    cdb_value[p*32 +: 32] = val;
  endtask

  initial begin
    rst_n_in = 1'b0; rdy_in = 1'b1; issue_ready = 1'b0;
    idle();
    #2;
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_issue_rob", issue_rob_id, 0);
    chk("rst_issue_r1", issue_r1, 0);
    repeat (2) tick();
    rst_n_in = 1'b1;

    // Eight independent ADDs, then drain in age order.
    for (int i = 0; i < 8; i++) begin
      disp(4'(i), 32'(i), 32'd1);
      #1;
      if (i == 0) chk("a_empty_no_issue", issue_valid, 0);
      if (i == 1) chk("a_count1", count, 1);
      tick();
    end
    idle();
    #1;
    chk("a_count8", count, 8);
    chk("a_full", full, 1);
    chk("a_valid", issue_valid, 1);
    issue_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("a_issue_rob", issue_rob_id, 64'(i));
      chk("a_issue_r1", issue_r1, 64'(i));
      chk("a_issue_r2", issue_r2, 1);
      if (i == 0) chk("a_issue_type", issue_type, ALU_ADD);
      tick();
      #1;
    end
    chk("a_drained_count", count, 0);
    chk("a_drained_valid", issue_valid, 0);
    chk("a_drained_full", full, 0);

    // Dependent older entry wakes via CDB port 1 and overtakes the younger one.
    issue_ready = 1'b0;
    disp(4'd3, 32'd0, 32'd2);
    inst_has_dep1 = 1'b1; inst_dep1 = 4'd9;
    tick();
    disp(4'd4, 32'd4, 32'd4);
    #1;
    chk("b_dep_blocks", issue_valid, 0);
    tick();
    idle();
    #1;
    chk("b_young_offered", issue_rob_id, 4);
    set_cdb(0, 4'd5, 32'h11);
    set_cdb(1, 4'd9, 32'h55);
    #1;
    chk("b_wake_rob", issue_rob_id, 3);
    chk("b_wake_r1", issue_r1, 32'h55);
    chk("b_wake_r2", issue_r2, 2);
    tick();
    idle();
    #1;
    chk("b_captured_rob", issue_rob_id, 3);
    chk("b_captured_r1", issue_r1, 32'h55);
    issue_ready = 1'b1;
    tick();
    #1;
    chk("b_second_rob", issue_rob_id, 4);
    tick();
    #1;
    chk("b_empty", count, 0);

    // Insert with same-cycle CDB match on both ports; port 0 wins.
    disp(4'd6, 32'hDEAD, 32'd3);
    inst_has_dep1 = 1'b1; inst_dep1 = 4'd7;
    set_cdb(0, 4'd7, 32'hA0);
    set_cdb(1, 4'd7, 32'hB0);
    #1;
    chk("c_not_same_cycle", issue_valid, 0);
    tick();
    idle();
    #1;
    chk("c_valid", issue_valid, 1);
    chk("c_rob", issue_rob_id, 6);
    chk("c_r1_port0", issue_r1, 32'hA0);
    chk("c_r2", issue_r2, 3);
    tick();
    #1;
    chk("c_empty", count, 0);

    // Full: insert ignored even with a same-cycle pop; then insert+pop at count 7.
    issue_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      disp(4'(i), 32'h10 + 32'(i), 32'd0);
      tick();
    end
    idle();
    #1;
    chk("d_full", full, 1);
    chk("d_count8", count, 8);
    disp(4'd8, 32'hFF, 32'd0);
    issue_ready = 1'b1;
    #1;
    chk("d_oldest", issue_rob_id, 0);
    tick();
    disp(4'd9, 32'h99, 32'd0);
    #1;
    chk("d_count7", count, 7);
    chk("d_not_full", full, 0);
    chk("d_next_rob", issue_rob_id, 1);
    tick();
    idle();
    #1;
    chk("d_count_still7", count, 7);
    for (int k = 0; k < 7; k++) begin
      chk("d_drain_rob", issue_rob_id, 64'(exp_tag[k]));
      chk("d_drain_r1", issue_r1, 64'(exp_r1[k]));
      tick();
      #1;
    end
    chk("d_empty", count, 0);

    // Flush beats same-cycle insert and pop.
    issue_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      disp(4'(i), 32'(i), 32'd0);
      tick();
    end
    disp(4'd5, 32'd5, 32'd0);
    flush_in = 1'b1;
    issue_ready = 1'b1;
    #1;
    chk("e_pre_count", count, 5);
    chk("e_flush_gate", issue_valid, 0);
    tick();
    idle();
    #1;
    chk("e_count", count, 0);
    chk("e_valid", issue_valid, 0);
    chk("e_full", full, 0);

    // Asynchronous reset in the middle of an issue cycle.
    issue_ready = 1'b0;
    for (int i = 1; i < 4; i++) begin
      disp(4'(i), 32'(i), 32'd0);
      tick();
    end
    idle();
    issue_ready = 1'b1;
    #1;
    chk("f_pre_valid", issue_valid, 1);
    chk("f_pre_count", count, 3);
    rst_n_in = 1'b0;
    #1;
    chk("f_async_valid", issue_valid, 0);
    chk("f_async_count", count, 0);
    chk("f_async_r1", issue_r1, 0);
    #2;
    rst_n_in = 1'b1;
    tick();
    #1;
    chk("f_after_count", count, 0);

    // Stall freezes everything.
    issue_ready = 1'b0;
    disp(4'd1, 32'h21, 32'd0);
    tick();
    disp(4'd2, 32'h22, 32'd0);
    tick();
    rdy_in = 1'b0;
    disp(4'd3, 32'h23, 32'd0);
    issue_ready = 1'b1;
    #1;
    chk("g_stall_valid", issue_valid, 0);
    tick();
    tick();
    #1;
    chk("g_stall_count", count, 2);
    chk("g_stall_valid2", issue_valid, 0);
    rdy_in = 1'b1;
    idle();
    #1;
    chk("g_resume_valid", issue_valid, 1);
    chk("g_resume_rob", issue_rob_id, 1);
    chk("g_resume_r1", issue_r1, 32'h21);
    tick();
    #1;
    chk("g_second_rob", issue_rob_id, 2);
    tick();
    #1;
    chk("g_empty", count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
